// File: rtl/scene_pkg.sv
// Shared sprite codes, scene geometry and helpers for the note scene builder.
package scene_pkg;

    localparam int NUM_SLOTS = 6;
    localparam int NUM_NOTES = NUM_SLOTS - 1;
    localparam int NUM_COLOURS = 4;

    localparam logic [4:0] PINK   = 5'd0;
    localparam logic [4:0] YELLOW = 5'd1;
    localparam logic [4:0] RED    = 5'd2;
    localparam logic [4:0] BLUE   = 5'd3;
    localparam logic [4:0] TARGET = 5'd4;
    localparam logic [4:0] BLANK  = 5'b01100;

    localparam logic [8:0] TARGET_X = 9'd64;
    localparam logic [7:0] TARGET_Y = 8'd104;
    localparam logic [7:0] NOTE_Y   = 8'd112;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADVANCE,
        ST_JUDGE,
        ST_SPAWN,
        ST_COMMIT
    } state_t;

    // Place one slot's sprite code at its position on the code bus.
    function automatic logic [5*NUM_SLOTS-1:0] pack_code(input int k, input logic [4:0] code);
        logic [5*NUM_SLOTS-1:0] bus;
        bus = '0;
        bus[5*k +: 5] = code;
        return bus;
    endfunction

    // Place one slot's {y, x} pair at its position on the position bus.
    function automatic logic [17*NUM_SLOTS-1:0] pack_pos(input int k, input logic [8:0] x,
                                                         input logic [7:0] y);
        logic [17*NUM_SLOTS-1:0] bus;
        bus = '0;
        bus[17*k +: 17] = {y, x};
        return bus;
    endfunction

endpackage

// File: rtl/key_edge_latch.sv
// Rising-edge detector with sticky pending bits; a consumed bit clears unless a
// fresh edge arrives in the same cycle.
module key_edge_latch #(
    parameter int W = 4
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic [W-1:0] key,
    input  logic [W-1:0] consume,
    output logic [W-1:0] pending
);

    logic [W-1:0] prev_reg;
    logic [W-1:0] pend_reg;
    logic [W-1:0] edges;

    assign edges = key & ~prev_reg;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            prev_reg <= '0;
            pend_reg <= '0;
        end else begin
            prev_reg <= key;
            pend_reg <= (pend_reg & ~consume) | edges;
        end
    end

    assign pending = pend_reg;

endmodule

// File: rtl/note_scene_builder.sv
// Per-frame sprite descriptor builder: scrolls notes, judges key presses against
// the hit window and publishes a consistent frame snapshot to the drawer.
module note_scene_builder
    import scene_pkg::*;
#(
    parameter int          STEP         = 2,
    parameter int          SPAWN_X      = 304,
    parameter int          HIT_LO       = 64,
    parameter int          HIT_HI       = 80,
    parameter int          FLASH_FRAMES = 4,
    parameter logic [11:0] BG_COLOUR    = 12'h000
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic         spawn_valid,
    input  logic [1:0]   spawn_colour,
    output logic         spawn_ready,
    input  logic [3:0]   key,
    output logic [29:0]  inputs,
    output logic [101:0] pos,
    output logic [7:0]   score,
    output logic [11:0]  background
);

    localparam logic [8:0]   STEP_X     = STEP[8:0];
    localparam logic [8:0]   SPAWN_X9   = SPAWN_X[8:0];
    localparam logic [8:0]   HIT_LO_X   = HIT_LO[8:0];
    localparam logic [8:0]   HIT_HI_X   = HIT_HI[8:0];
    localparam logic [7:0]   FLASH_LOAD = FLASH_FRAMES[7:0];
    localparam logic [11:0]  MISS_RED   = 12'hF00;
    localparam logic [29:0]  RESET_INPUTS = {{NUM_NOTES{BLANK}}, TARGET};
    localparam logic [101:0] RESET_POS    = {85'd0, TARGET_Y, TARGET_X};

    state_t               state_reg, state_next;
    logic [NUM_NOTES-1:0] active_reg, active_next;
    logic [1:0]           colour_reg [NUM_NOTES];
    logic [1:0]           colour_next [NUM_NOTES];
    logic [8:0]           x_reg [NUM_NOTES];
    logic [8:0]           x_next [NUM_NOTES];
    logic                 spawn_pend_reg, spawn_pend_next;
    logic [1:0]           spawn_col_reg, spawn_col_next;
    logic                 miss_reg, miss_next;
    logic [7:0]           hits_reg, hits_next;
    logic [7:0]           flash_reg, flash_next;
    logic [3:0]           press_pend;
    logic [3:0]           consume;
    logic                 found;

    logic [29:0]          frame_inputs, inputs_reg;
    logic [101:0]         frame_pos, pos_reg;
    logic [7:0]           score_reg;
    logic [11:0]          background_reg;

    key_edge_latch #(.W(NUM_COLOURS)) u_key_edge_latch (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key      (key),
        .consume  (consume),
        .pending  (press_pend)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            active_reg     <= '0;
            for (int i = 0; i < NUM_NOTES; i++) begin
                colour_reg[i] <= '0;
                x_reg[i]      <= '0;
            end
            spawn_pend_reg <= 1'b0;
            spawn_col_reg  <= '0;
            miss_reg       <= 1'b0;
            hits_reg       <= '0;
            flash_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            active_reg     <= active_next;
            colour_reg     <= colour_next;
            x_reg          <= x_next;
            spawn_pend_reg <= spawn_pend_next;
            spawn_col_reg  <= spawn_col_next;
            miss_reg       <= miss_next;
            hits_reg       <= hits_next;
            flash_reg      <= flash_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        active_next     = active_reg;
        colour_next     = colour_reg;
        x_next          = x_reg;
        spawn_pend_next = spawn_pend_reg;
        spawn_col_next  = spawn_col_reg;
        miss_next       = miss_reg;
        hits_next       = hits_reg;
        flash_next      = flash_reg;
        consume         = '0;
        spawn_ready     = 1'b0;
        found           = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                spawn_ready = ~reset & ~(&active_reg) & ~spawn_pend_reg;
                if (spawn_valid && spawn_ready) begin
                    spawn_pend_next = 1'b1;
                    spawn_col_next  = spawn_colour;
                end
                if (frame_tick) begin
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                for (int i = 0; i < NUM_NOTES; i++) begin
                    if (active_reg[i]) begin
                        if (x_reg[i] < STEP_X) begin
                            active_next[i] = 1'b0;
                            miss_next      = 1'b1;
                        end else begin
                            x_next[i] = x_reg[i] - STEP_X;
                        end
                    end
                end
                state_next = ST_JUDGE;
            end
            ST_JUDGE: begin
                consume = press_pend;
                // Colours never share a slot, so each colour searches independently.
                for (int c = 0; c < NUM_COLOURS; c++) begin
                    found = 1'b0;
                    if (press_pend[c]) begin
                        for (int i = 0; i < NUM_NOTES; i++) begin
                            if (!found && active_reg[i] && colour_reg[i] == 2'(c) &&
                                x_reg[i] >= HIT_LO_X && x_reg[i] <= HIT_HI_X) begin
                                active_next[i] = 1'b0;
                                found          = 1'b1;
                            end
                        end
                        if (!found) begin
                            miss_next = 1'b1;
                        end else if (hits_next != 8'hFF) begin
                            hits_next = hits_next + 8'd1;
                        end
                    end
                end
                state_next = ST_SPAWN;
            end
            ST_SPAWN: begin
                if (spawn_pend_reg) begin
                    for (int i = 0; i < NUM_NOTES; i++) begin
                        if (!found && !active_reg[i]) begin
                            active_next[i] = 1'b1;
                            colour_next[i] = spawn_col_reg;
                            x_next[i]      = SPAWN_X9;
                            found          = 1'b1;
                        end
                    end
                    spawn_pend_next = 1'b0;
                end
                state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (miss_reg) begin
                    flash_next = FLASH_LOAD;
                end else if (flash_reg != 8'd0) begin
                    flash_next = flash_reg - 8'd1;
                end
                miss_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_inputs = pack_code(0, TARGET);
        frame_pos    = pack_pos(0, TARGET_X, TARGET_Y);
        for (int k = 1; k < NUM_SLOTS; k++) begin
            frame_inputs = frame_inputs |
                           pack_code(k, active_reg[k-1] ? {3'b000, colour_reg[k-1]} : BLANK);
            frame_pos    = frame_pos | pack_pos(k, x_reg[k-1], NOTE_Y);
        end
    end

    // All drawer-facing outputs change together, only on the COMMIT edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            inputs_reg     <= RESET_INPUTS;
            pos_reg        <= RESET_POS;
            score_reg      <= '0;
            background_reg <= BG_COLOUR;
        end else if (state_reg == ST_COMMIT) begin
            inputs_reg     <= frame_inputs;
            pos_reg        <= frame_pos;
            score_reg      <= hits_reg;
            background_reg <= (flash_next != 8'd0) ? MISS_RED : BG_COLOUR;
        end
    end

    assign inputs     = inputs_reg;
    assign pos        = pos_reg;
    assign score      = score_reg;
    assign background = background_reg;

endmodule

// File: tb/tb_note_scene_builder.sv
// Directed plus randomized bench for note_scene_builder against a frame-level model.
module tb_note_scene_builder;

    logic         CLOCK_50 = 1'b0;
    logic         reset = 1'b1;
    logic         frame_tick = 1'b0;
    logic         spawn_valid = 1'b0;
    logic [1:0]   spawn_colour = 2'd0;
    logic         spawn_ready;
    logic [3:0]   key = 4'd0;
    logic [29:0]  inputs;
    logic [101:0] pos;
    logic [7:0]   score;
    logic [11:0]  background;

    int total = 0;
    int bad = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    note_scene_builder dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .spawn_valid  (spawn_valid),
        .spawn_colour (spawn_colour),
        .spawn_ready  (spawn_ready),
        .key          (key),
        .inputs       (inputs),
        .pos          (pos),
        .score        (score),
        .background   (background)
    );

    // Frame-level model of the scene.
    bit       m_act [5];
    int       m_col [5];
    int       m_x [5];
    int       m_score;
    int       m_flash;
    bit [3:0] m_pend;
    bit [3:0] m_prev;
    bit       m_spend;
    int       m_scol;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_act[i] = 0; m_col[i] = 0; m_x[i] = 0;
        end
        m_score = 0; m_flash = 0; m_pend = 0; m_prev = 0; m_spend = 0; m_scol = 0;
    endtask

    function automatic bit m_free();
        for (int i = 0; i < 5; i++) if (!m_act[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Colours that have a note inside the hit window after the next advance.
    function automatic logic [3:0] window_keys();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            if (m_act[i] && m_x[i] - 2 >= 64 && m_x[i] - 2 <= 80) r[m_col[i]] = 1'b1;
        return r;
    endfunction

    task automatic model_frame(input logic [3:0] kmid);
        bit miss;
        bit hit;
        miss = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_act[i]) begin
                if (m_x[i] < 2) begin m_act[i] = 0; miss = 1; end
                else m_x[i] = m_x[i] - 2;
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (m_pend[c]) begin
                hit = 0;
                for (int i = 0; i < 5; i++) begin
                    if (!hit && m_act[i] && m_col[i] == c && m_x[i] >= 64 && m_x[i] <= 80) begin
                        m_act[i] = 0; hit = 1;
                    end
                end
                if (hit) begin
                    if (m_score < 255) m_score++;
                end else miss = 1;
            end
        end
        m_pend = kmid & ~m_prev;
        m_prev = kmid;
        if (m_spend) begin
            hit = 0;
            for (int i = 0; i < 5; i++) begin
                if (!hit && !m_act[i]) begin
                    m_act[i] = 1; m_col[i] = m_scol; m_x[i] = 304; hit = 1;
                end
            end
            m_spend = 0;
        end
        m_flash = miss ? 4 : (m_flash > 0 ? m_flash - 1 : 0);
    endtask

    task automatic check_frame();
        logic [29:0]  ei;
        logic [101:0] ep;
        logic [101:0] mask;
        ei = 30'd4;
        ep = {85'd0, 8'd104, 9'd64};
        mask = {85'd0, 17'h1FFFF};
        for (int k = 0; k < 5; k++) begin
            ei[5*(k+1) +: 5] = m_act[k] ? 5'(m_col[k]) : 5'd12;
            if (m_act[k]) begin
                ep[17*(k+1) +: 17] = {8'd112, 9'(m_x[k])};
                mask[17*(k+1) +: 17] = 17'h1FFFF;
            end
        end
        chk("inputs", inputs, ei);
        chk("pos", pos & mask, ep);
        chk("score", score, m_score);
        chk("background", background, (m_flash != 0) ? 12'hF00 : 12'h000);
        $display("frame: inputs=%h score=%0d bg=%h", inputs, score, background);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_inputs"}, inputs, 30'h18C6_3184);
        chk({tag, "_pos"}, pos, {85'd0, 8'd104, 9'd64});
        chk({tag, "_score"}, score, 8'd0);
        chk({tag, "_bg"}, background, 12'h000);
        chk({tag, "_ready"}, spawn_ready, 1'b0);
    endtask

    // One IDLE cycle: optional spawn request and a new key level.
    task automatic idle_cycle(input bit sv, input int col, input logic [3:0] kv);
        bit rdy;
        @(negedge CLOCK_50);
        frame_tick = 0; spawn_valid = sv; spawn_colour = col[1:0]; key = kv;
        #1;
        rdy = m_free() && !m_spend;
        chk("spawn_ready", spawn_ready, rdy);
        @(posedge CLOCK_50);
        if (sv && rdy) begin m_spend = 1; m_scol = col; end
        m_pend = m_pend | (kv & ~m_prev);
        m_prev = kv;
        @(negedge CLOCK_50);
        spawn_valid = 0;
    endtask

    // One full frame; kmid is driven so that it lands on the JUDGE edge.
    task automatic frame(input logic [3:0] kmid);
        @(negedge CLOCK_50);
        spawn_valid = 0; frame_tick = 1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        frame_tick = 0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        key = kmid;
        chk("ready_busy", spawn_ready, 1'b0);
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        model_frame(kmid);
        check_frame();
    endtask

    initial begin
        logic [3:0] kv;
        int g;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset("reset");
        reset = 0;

        idle_cycle(0, 0, 4'd0);
        chk("idle_inputs", inputs, 30'h18C6_3184);

        // Spawn RED and scroll it to x = 70.
        idle_cycle(1, 2, 4'd0);
        frame(4'd0);
        chk("spawn_code", inputs[9:5], 5'd2);
        chk("spawn_pos", pos[33:17], {8'd112, 9'd304});
        repeat (117) frame(4'd0);
        chk("x70", pos[25:17], 9'd70);

        // Hit, then a press with nothing in the window.
        idle_cycle(0, 0, 4'b0100);
        frame(4'd0);
        chk("hit_score", score, 8'd1);
        chk("hit_blank", inputs[9:5], 5'd12);
        chk("hit_bg", background, 12'h000);
        idle_cycle(0, 0, 4'b0100);
        frame(4'd0);
        chk("miss_bg", background, 12'hF00);
        repeat (3) frame(4'd0);
        chk("flash_last", background, 12'hF00);
        frame(4'd0);
        chk("flash_end", background, 12'h000);

        // Unhit note scrolls off the left edge.
        idle_cycle(1, 3, 4'd0);
        frame(4'd0);
        repeat (152) frame(4'd0);
        chk("x_zero", pos[25:17], 9'd0);
        frame(4'd0);
        chk("offedge_blank", inputs[9:5], 5'd12);
        chk("offedge_bg", background, 12'hF00);
        chk("offedge_score", score, 8'd1);

        // Fill all note slots, then free one by a hit.
        for (int i = 0; i < 5; i++) begin
            idle_cycle(1, i % 4, 4'd0);
            frame(4'd0);
        end
        idle_cycle(0, 0, 4'd0);
        chk("full_ready", spawn_ready, 1'b0);
        g = 0;
        while (!(m_act[0] && m_x[0] - 2 <= 80) && g < 200) begin
            frame(4'd0);
            g++;
        end
        idle_cycle(0, 0, 4'b0001);
        frame(4'd0);
        idle_cycle(1, 3, 4'd0);
        frame(4'd0);
        chk("refill_slot1", inputs[9:5], 5'd3);
        chk("refill_x", pos[25:17], 9'd304);

        // Randomized frames, including key edges during JUDGE.
        for (int n = 0; n < 300; n++) begin
            kv = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom % 2 == 0) kv = kv | window_keys();
            idle_cycle($urandom % 2 == 0, int'($urandom % 4), kv);
            frame(($urandom % 4 == 0) ? 4'($urandom) : kv);
        end

        // Drive the score to saturation.
        g = 0;
        while (m_score < 255 && g < 8000) begin
            idle_cycle(m_free() && !m_spend, int'($urandom % 4), window_keys());
            frame(4'd0);
            g++;
        end
        chk("score_255", score, 8'd255);
        repeat (150) begin
            idle_cycle(m_free() && !m_spend, int'($urandom % 4), window_keys());
            frame(4'd0);
        end
        chk("score_sat", score, 8'd255);

        // Reset asserted while the FSM is in SPAWN with a note pending.
        g = 0;
        while (!(m_free() && !m_spend) && g < 300) begin
            frame(4'd0);
            g++;
        end
        idle_cycle(1, 1, 4'd0);
        @(negedge CLOCK_50);
        frame_tick = 1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        frame_tick = 0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1;
        #1;
        check_reset("rst_spawn");
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset("rst_hold");
        reset = 0;
        model_reset();
        idle_cycle(0, 0, 4'd0);
        frame(4'd0);
        chk("no_spawn_after_reset", inputs, 30'h18C6_3184);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_scene_builder.md
# note_scene_builder

Produces the per-frame sprite descriptors for the graphics drawer: the 30-bit sprite-code bus (six 5-bit codes), the 102-bit position bus (six packed 9-bit x / 8-bit y pairs), the 8-bit score and the 12-bit background colour. Slot 0 is always the hit target; slots 1-5 hold scrolling notes. Each note advances right-to-left once per frame tick. Key presses are judged against the target window, and the score and miss flash are updated from the result. Sits between the song/chart sequencer (note source) and the drawer.

## Interface
- STEP, 2: pixels a note moves per frame tick.
- SPAWN_X, 304: x of a newly spawned note.
- HIT_LO, 64: lowest note x counted as a hit, inclusive.
- HIT_HI, 80: highest note x counted as a hit, inclusive.
- FLASH_FRAMES, 4: frames the background stays red after a miss.
- BG_COLOUR, 12'h000: normal background colour.
- CLOCK_50  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per redraw.
- spawn_valid  in  1  chart requests a note.
- spawn_colour  in  2  note colour: PINK=0, YELLOW=1, RED=2, BLUE=3.
- spawn_ready  out  1  a spawn can be accepted this cycle.
- key  in  4  level per colour, bit index = colour code, already synchronised.
- inputs  out  30  sprite code of slot k at [5k+4:5k].
- pos  out  102  slot k: x at [17k+8:17k], y at [17k+16:17k+9].
- score  out  8  hit count, saturating.
- background  out  12  background colour.

## Operation
- Slot state (slots 1-5):
  - active bit, 2-bit colour, 9-bit x.
  - Slot 0 output is constant: code 5'd4 (Target), x=64, y=104.
- Output code per note slot:
  - active: {3'b000, colour}.
  - inactive: 5'b01100 (blank).
  - Note y is always 112.
- Key edge latch:
  - A rising edge on key[c] sets press_pend[c].
  - press_pend[c] is sticky until consumed in JUDGE.
  - Clear rule: new = (pend & ~consumed) | edges. An edge arriving in the JUDGE cycle itself is kept for the next frame.
- FSM: IDLE -> ADVANCE -> JUDGE -> SPAWN -> COMMIT -> IDLE.
  - IDLE:
    - spawn_ready = (a free slot exists) & ~spawn_pend.
    - spawn_valid & spawn_ready latches the colour and sets spawn_pend.
    - frame_tick moves to ADVANCE.
  - ADVANCE, for each active slot:
    - if x < STEP: retire the slot and raise miss.
    - otherwise x -= STEP. There is no wrap: x == STEP becomes 0 and stays active.
  - JUDGE, for each colour c with press_pend[c]:
    - The lowest-index active slot with colour c and HIT_LO ≤ x ≤ HIT_HI is retired and score += 1 (saturates at 255).
    - If no slot matches, raise miss.
    - At most one slot retires per colour per frame.
  - SPAWN:
    - If spawn_pend, load the lowest-index inactive slot with {active=1, colour, x=SPAWN_X} and clear spawn_pend.
    - A free slot is guaranteed, because acceptance required one and JUDGE/ADVANCE only free slots.
  - COMMIT:
    - Registers inputs, pos, score and background together, so the drawer never sees a half-updated frame.
    - Flash counter: any miss this frame loads FLASH_FRAMES; otherwise it decrements if nonzero.
    - background = (flash ≠ 0) ? 12'hF00 : BG_COLOUR.

## Timing
- frame_tick sampled in IDLE at edge N: ADVANCE at N+1, JUDGE at N+2, SPAWN at N+3, outputs valid after edge N+4.
- frame_tick outside IDLE is ignored and not queued.
- spawn_ready is combinational from state and slot occupancy. It is 0 outside IDLE.
- Acceptance happens on the edge where valid and ready are both high. The spawned note first appears in the outputs of the next frame's COMMIT.
- Reset values (asynchronous), in effect immediately and held while reset is high:
  - FSM = IDLE; all slots, press_pend, spawn_pend and flash cleared.
  - inputs = {5 × 5'b01100, 5'd4}.
  - pos slot 0 = {8'd104, 9'd64}; other slots 0.
  - score = 0; background = BG_COLOUR; spawn_ready = 0.
- Reset mid-frame discards the frame in progress with no partial output update.
- Simultaneous miss from ADVANCE and hit from JUDGE in one frame: both apply; the score increments and the flash is set.

## Structure
- Package scene_pkg:
  - Sprite codes: PINK, YELLOW, RED, BLUE, TARGET=4, BLANK=5'b01100.
  - TARGET_X=64, TARGET_Y=104, NOTE_Y=112.
  - NUM_SLOTS=6, and a slot-pack function from (k, code, x, y) to bus bit positions.
  - FSM state enumeration.
- Sub-module key_edge_latch: 4-bit previous-value register, edge detect, sticky pending with the consume-clear rule above.

## Test plan
- Reset then idle: inputs = 30'h18C6_3184 (five blanks + target), pos[16:0] = {104,64}, score 0, spawn_ready 1.
- Spawn RED, then one frame_tick: slot 1 code 2, x 304, y 112 after N+4. After 120 more ticks, x = 64.
- Press key[2] with a RED note at x = 70 → slot retired (blank), score 1, background unchanged. Press again with no note in window → background 12'hF00 for 4 frames, then BG_COLOUR.
- Note left unhit for 153 ticks from spawn: retired when x < 2, miss flash set, score unchanged.
- Fill slots 1-5 → spawn_ready 0. Hit one note → spawn_ready 1 in the following IDLE, and the new note lands in the freed slot index.
- Score at 255 plus a hit → stays 255. Assert reset during SPAWN → all outputs at their reset values asynchronously, no note loaded.
